// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR MAC sequencer.
package fir_pkg;
    localparam int DATA_W = 16;
    localparam int PROD_W = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUTPUT
    } fir_state_e;
endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift of the accumulator, saturated to a 16-bit sample.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 35,
    parameter int SHIFT = 15
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] data_o
);
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) <<< (SHIFT-1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        biased  = {acc_i[ACC_W-1], acc_i} + HALF;
        shifted = biased >>> SHIFT;
        if (shifted > SAT_MAX) begin
            data_o = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            data_o = SAT_MIN[DATA_W-1:0];
        end else begin
            data_o = shifted[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR control/datapath: circular delay line, coefficient file, tap streaming to the
// external ALU, product accumulation and rounded/saturated output.
//   state  | meaning
//   IDLE   | ready for a sample; coefficient writes allowed
//   ISSUE  | presenting one (sample, coef) tap per cycle to the ALU
//   DRAIN  | waiting for the last ALU products to land in the accumulator
//   OUTPUT | out_valid held until the downstream handshake
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS    = 8,
    parameter int ALU_LAT = 1,
    parameter int SHIFT   = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       coef_we_i,
    input  logic [$clog2(TAPS)-1:0]    coef_addr_i,
    input  logic signed [DATA_W-1:0]   coef_wdata_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic signed [DATA_W-1:0]   in_data_i,
    output logic [1:0]                 alu_op_sel_o,
    output logic signed [DATA_W-1:0]   alu_a_o,
    output logic signed [DATA_W-1:0]   alu_b_o,
    input  logic signed [PROD_W-1:0]   alu_result_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [DATA_W-1:0]   out_data_o,
    output logic                       busy_o
);
    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = PROD_W + AW;

    fir_state_e               state_q;
    logic signed [DATA_W-1:0] delay_q [TAPS];
    logic signed [DATA_W-1:0] coef_q  [TAPS];
    logic [AW-1:0]            wr_ptr_q, base_q, k_q, k_nxt;
    logic signed [ACC_W-1:0]  acc_q, acc_d, prod_ext;
    logic [ALU_LAT:0]         vld_sr_q;
    logic                     issue_bit, drain_done;
    logic signed [DATA_W-1:0] tap0_coef, rnd_data;
    logic signed [DATA_W-1:0] alu_a_q, alu_b_q, out_data_q;
    logic [1:0]               alu_op_q;
    logic                     in_ready_q, out_valid_q, busy_q;

    assign k_nxt      = k_q + 1'b1;
    assign tap0_coef  = (coef_we_i && coef_addr_i == '0) ? coef_wdata_i : coef_q[0];
    assign issue_bit  = (state_q == ST_IDLE && in_valid_i) ||
                        (state_q == ST_ISSUE && k_q != AW'(TAPS-1));
    // bit 0 is aligned with the operands on the bus, bit ALU_LAT with alu_result_i
    assign prod_ext   = vld_sr_q[ALU_LAT] ? ACC_W'(alu_result_i) : '0;
    assign acc_d      = acc_q + prod_ext;
    assign drain_done = (vld_sr_q[ALU_LAT-1:0] == '0);

    fir_round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_round_sat (
        .acc_i  (acc_d),
        .data_o (rnd_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
            wr_ptr_q    <= '0;
            base_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            vld_sr_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_MUL;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vld_sr_q <= {vld_sr_q[ALU_LAT-1:0], issue_bit};
            acc_q    <= acc_d;
            alu_op_q <= OP_MUL;
            case (state_q)
                ST_IDLE: begin
                    if (coef_we_i) begin
                        coef_q[coef_addr_i] <= coef_wdata_i;
                    end
                    if (in_valid_i) begin
                        delay_q[wr_ptr_q] <= in_data_i;
                        base_q            <= wr_ptr_q;
                        wr_ptr_q          <= wr_ptr_q + 1'b1;
                        k_q               <= '0;
                        acc_q             <= '0;
                        alu_a_q           <= in_data_i;
                        alu_b_q           <= tap0_coef;
                        in_ready_q        <= 1'b0;
                        busy_q            <= 1'b1;
                        state_q           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (k_q == AW'(TAPS-1)) begin
                        alu_a_q <= '0;
                        alu_b_q <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        k_q     <= k_nxt;
                        alu_a_q <= delay_q[base_q - k_nxt];
                        alu_b_q <= coef_q[k_nxt];
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        out_data_q  <= rnd_data;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign alu_op_sel_o = alu_op_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a one-cycle registered ALU model.
module tb_fir_mac_sequencer;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               coef_we = 1'b0;
    logic [2:0]         coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_data = '0;
    logic [1:0]         alu_op_sel;
    logic signed [15:0] alu_a, alu_b;
    logic signed [31:0] alu_result;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_data;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer #(.TAPS(8), .ALU_LAT(1), .SHIFT(15)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .coef_we_i    (coef_we),
        .coef_addr_i  (coef_addr),
        .coef_wdata_i (coef_wdata),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .alu_op_sel_o (alu_op_sel),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_result_i (alu_result),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .busy_o       (busy)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) alu_result <= '0;
        else begin
            case (alu_op_sel)
                2'b00:   alu_result <= alu_a + alu_b;
                2'b01:   alu_result <= alu_a * alu_b;
                2'b10:   alu_result <= alu_a - alu_b;
                default: alu_result <= '0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Sends one sample (optionally writing coef[0] in the accept cycle) and returns
    // the output value and the cycles from accept to out_valid.
    task automatic send_sample(input logic [15:0] d, input logic we0, input logic [15:0] wd0,
                               output logic [15:0] got, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        coef_we = we0; coef_addr = '0; coef_wdata = wd0;
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        got = out_data;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (alu_op_sel !== 2'b01) begin n_fail++; $display("FAIL reset_alu_op got %b want 01", alu_op_sel); end
        n_checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0) begin n_fail++; $display("FAIL reset_operands got %h/%h want 0/0", alu_a, alu_b); end
        n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        rst = 1'b0;
    endtask

    task automatic test_impulse();
        logic [15:0] got, exp;
        int lat;
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(16'h0800 * (k + 1)));
        for (int n = 0; n < 16; n++) begin
            send_sample((n == 0) ? 16'h4000 : 16'h0000, 1'b0, 16'h0, got, lat);
            exp = (n < 8) ? 16'(16'h0400 * (n + 1)) : 16'h0000;
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL impulse_out[%0d] got %h want %h", n, got, exp); end
            n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL impulse_latency[%0d] got %0d want 10", n, lat); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] got;
        int lat;
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'h7FFF);
        for (int n = 0; n < 8; n++) begin
            send_sample(16'h7FFF, 1'b0, 16'h0, got, lat);
            if (n == 0) begin
                n_checks++; if (got !== 16'h7FFE) begin n_fail++; $display("FAIL sat_pos_first got %h want 7ffe", got); end
            end
        end
        n_checks++; if (got !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_8th got %h want 7fff", got); end
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'h7FFF);
        for (int n = 0; n < 8; n++) begin
            send_sample(16'h8000, 1'b0, 16'h0, got, lat);
            if (n == 0) begin
                n_checks++; if (got !== 16'h8001) begin n_fail++; $display("FAIL sat_neg_first got %h want 8001", got); end
            end
        end
        n_checks++; if (got !== 16'h8000) begin n_fail++; $display("FAIL sat_neg_8th got %h want 8000", got); end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        int guard = 0;
        do_reset();
        write_coef(3'd0, 16'h4000);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0100; out_ready = 1'b0;
        @(negedge clk);
        in_data = 16'h0200;
        while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
        held = out_data;
        n_checks++; if (held !== 16'h0080) begin n_fail++; $display("FAIL bp_first_out got %h want 0080", held); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL bp_hold[%0d] got valid %b data %h want 1 %h", i, out_valid, out_data, held); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got ready %b busy %b want 1 0", in_ready, busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept got busy %b ready %b want 1 0", busy, in_ready); end
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
        n_checks++; if (out_data !== 16'h0100) begin n_fail++; $display("FAIL bp_second_out got %h want 0100", out_data); end
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra got busy %b valid %b want 0 0", busy, out_valid); end
    endtask

    task automatic test_reset_mid_issue();
        logic [15:0] got, exp;
        int lat;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(16'h0800 * (k + 1)));
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (alu_a !== 16'h1234 || alu_b !== 16'h0800) begin n_fail++; $display("FAIL mid_tap0 got %h/%h want 1234/0800", alu_a, alu_b); end
        repeat (3) @(negedge clk);
        n_checks++; if (alu_a !== 16'h0000 || alu_b !== 16'h2000 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_tap3 got %h/%h busy %b want 0000/2000 1", alu_a, alu_b, busy); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl got ready %b busy %b valid %b want 1 0 0", in_ready, busy, out_valid); end
        n_checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op_sel !== 2'b01 || out_data !== 16'h0) begin n_fail++; $display("FAIL mid_reset_data got %h/%h op %b out %h want 0/0 01 0", alu_a, alu_b, alu_op_sel, out_data); end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(16'h0800 * (k + 1)));
        for (int n = 0; n < 16; n++) begin
            send_sample((n == 0) ? 16'h4000 : 16'h0000, 1'b0, 16'h0, got, lat);
            exp = (n < 8) ? 16'(16'h0400 * (n + 1)) : 16'h0000;
            n_checks++; if (got !== exp || lat !== 10) begin n_fail++; $display("FAIL mid_impulse[%0d] got %h lat %0d want %h lat 10", n, got, lat, exp); end
        end
    endtask

    task automatic test_coef_busy();
        logic [15:0] got;
        int lat;
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h4000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h7FFF;
        @(negedge clk);
        coef_we = 1'b0;
        while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
        n_checks++; if (out_data !== 16'h0400) begin n_fail++; $display("FAIL coef_busy_out got %h want 0400", out_data); end
        send_sample(16'h4000, 1'b0, 16'h0, got, lat);
        n_checks++; if (got !== 16'h0C00) begin n_fail++; $display("FAIL coef_busy_next got %h want 0c00", got); end
    endtask

    task automatic test_rounding();
        logic [15:0] got;
        int lat;
        do_reset();
        send_sample(16'h4000, 1'b1, 16'h0001, got, lat);
        n_checks++; if (got !== 16'h0001 || lat !== 10) begin n_fail++; $display("FAIL round_pos_half got %h lat %0d want 0001 lat 10", got, lat); end
        send_sample(16'hC000, 1'b0, 16'h0, got, lat);
        n_checks++; if (got !== 16'h0000 || lat !== 10) begin n_fail++; $display("FAIL round_neg_half got %h lat %0d want 0000 lat 10", got, lat); end
        send_sample(16'h3FFF, 1'b0, 16'h0, got, lat);
        n_checks++; if (got !== 16'h0000 || lat !== 10) begin n_fail++; $display("FAIL round_below_half got %h lat %0d want 0000 lat 10", got, lat); end
        send_sample(16'hBFFF, 1'b0, 16'h0, got, lat);
        n_checks++; if (got !== 16'hFFFF || lat !== 10) begin n_fail++; $display("FAIL round_neg_below got %h lat %0d want ffff lat 10", got, lat); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_saturation();
        test_backpressure();
        test_reset_mid_issue();
        test_coef_busy();
        test_rounding();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
